// File: rtl/td4_step_ctrl.sv
// rtl/td4_step_ctrl.sv - TD4 key debounce and RUN/STEP CPU clock controller (optional TD4_STEP_COUNT_EN adds STEP_COUNT)
module td4_step_ctrl #(
    parameter int DIV_W        = 23,
    parameter int DEB_CYCLES   = 240000,
    parameter int LONG_CYCLES  = 24000000,
    parameter int PULSE_CYCLES = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KEY,
    output logic       CPU_CLK,
    output logic       KEY_LEVEL,
    output logic       MODE,
    output logic       BUSY
`ifdef TD4_STEP_COUNT_EN
    ,
    output logic [7:0] STEP_COUNT
`endif
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int PUL_W  = $clog2(PULSE_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [PUL_W-1:0]  PUL_LAST  = PUL_W'(PULSE_CYCLES - 1);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_LONG  = 3'd4;

    logic              key_meta;
    logic              key_s;
    logic [DEB_W-1:0]  deb_cnt;
    logic              key_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_evt;
    logic [2:0]        state;
    logic [DIV_W-1:0]  div;
    logic [PUL_W-1:0]  pulse_cnt;
    logic              rise;
    logic              fall;

    assign rise = KEY_LEVEL & ~key_prev;
    assign fall = ~KEY_LEVEL & key_prev;

    // Two-flop synchroniser; KEY is active-low so invert on the way in
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_meta <= 1'b0;
            key_s    <= 1'b0;
        end else begin
            key_meta <= ~KEY;
            key_s    <= key_meta;
        end
    end

    // Accept a new key level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_cnt   <= '0;
            KEY_LEVEL <= 1'b0;
        end else if (key_s != KEY_LEVEL) begin
            if (deb_cnt == DEB_LAST) begin
                KEY_LEVEL <= key_s;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // Previous debounced level for edge detection
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) key_prev <= 1'b0;
        else       key_prev <= KEY_LEVEL;
    end

    // Press duration counter; saturation guarantees a single long_evt per press
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_cnt <= '0;
            long_evt <= 1'b0;
        end else if (!KEY_LEVEL) begin
            hold_cnt <= '0;
            long_evt <= 1'b0;
        end else begin
            long_evt <= (hold_cnt == HOLD_PRE);
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Mode FSM and CPU clock generation; every mode change drives CPU_CLK low
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_RUN;
            div       <= '0;
            pulse_cnt <= '0;
            CPU_CLK   <= 1'b0;
            MODE      <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (long_evt) begin
                        MODE    <= 1'b1;
                        state   <= S_LONG;
                        div     <= '0;
                        CPU_CLK <= 1'b0;
                    end else if (KEY_LEVEL) begin
                        div     <= '0;
                        CPU_CLK <= 1'b0;
                    end else begin
                        div     <= div + 1'b1;
                        CPU_CLK <= div[DIV_W-1];
                    end
                end
                S_IDLE: begin
                    CPU_CLK <= 1'b0;
                    BUSY    <= 1'b0;
                    if (rise) state <= S_ARMED;
                end
                S_ARMED: begin
                    CPU_CLK <= 1'b0;
                    if (long_evt) begin
                        MODE  <= 1'b0;
                        state <= S_LONG;
                    end else if (fall) begin
                        state     <= S_PULSE;
                        pulse_cnt <= '0;
                        CPU_CLK   <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (pulse_cnt == PUL_LAST) begin
                        CPU_CLK <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                S_LONG: begin
                    CPU_CLK <= 1'b0;
                    if (fall) begin
                        if (MODE) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_RUN;
                            div   <= '0;
                        end
                    end
                end
                default: begin
                    state   <= S_RUN;
                    CPU_CLK <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

`ifdef TD4_STEP_COUNT_EN
    logic cpu_clk_d;

    // Count CPU clock rising edges in either mode, wrapping at 8 bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cpu_clk_d  <= 1'b0;
            STEP_COUNT <= 8'd0;
        end else begin
            cpu_clk_d <= CPU_CLK;
            if (CPU_CLK && !cpu_clk_d) STEP_COUNT <= STEP_COUNT + 8'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_td4_step_ctrl.sv
// tb/tb_td4_step_ctrl.sv - directed self-checking bench for td4_step_ctrl
module tb_td4_step_ctrl;

    logic CLK;
    logic RESET;
    logic KEY;
    logic CPU_CLK;
    logic KEY_LEVEL;
    logic MODE;
    logic BUSY;
`ifdef TD4_STEP_COUNT_EN
    logic [7:0] STEP_COUNT;
`endif

    int checks;
    int errors;

    logic [63:0] pat;
    logic [63:0] busy_pat;
    int          idx;
    int          hi_cnt;
    int          rise_cnt;
    int          tot_rise;
    logic        lvl_or;
    logic        prev_clk;
    logic        found;

    td4_step_ctrl #(
        .DIV_W       (3),
        .DEB_CYCLES  (4),
        .LONG_CYCLES (32),
        .PULSE_CYCLES(2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY       (KEY),
        .CPU_CLK   (CPU_CLK),
        .KEY_LEVEL (KEY_LEVEL),
        .MODE      (MODE),
        .BUSY      (BUSY)
`ifdef TD4_STEP_COUNT_EN
        ,
        .STEP_COUNT(STEP_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task clear_acc;
        pat      = '0;
        busy_pat = '0;
        idx      = 0;
        hi_cnt   = 0;
        rise_cnt = 0;
        lvl_or   = 1'b0;
        prev_clk = CPU_CLK;
    endtask

    task run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (idx < 64) begin
                pat[idx]      = CPU_CLK;
                busy_pat[idx] = BUSY;
            end
            idx++;
            if (CPU_CLK && !prev_clk) begin
                rise_cnt++;
                tot_rise++;
            end
            if (CPU_CLK) hi_cnt++;
            lvl_or   = lvl_or | KEY_LEVEL;
            prev_clk = CPU_CLK;
        end
    endtask

    task short_press;
        KEY = 1'b0;
        run(10);
        KEY = 1'b1;
        run(20);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        tot_rise = 0;
        RESET    = 1'b1;
        KEY      = 1'b1;
        clear_acc();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("rst_key_level", 32'(KEY_LEVEL), 32'd0);
        check("rst_mode", 32'(MODE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);

        // Free-running RUN clock: 4 low, 4 high
        RESET = 1'b0;
        clear_acc();
        run(16);
        check("run_pattern", 32'(pat[15:0]), 32'h0000_F0F0);
        check("run_key_level", 32'(lvl_or), 32'd0);

        // 3-cycle glitch is rejected and the clock is undisturbed
        clear_acc();
        KEY = 1'b0;
        run(3);
        KEY = 1'b1;
        run(13);
        check("glitch_pattern", 32'(pat[15:0]), 32'h0000_F0F0);
        check("glitch_key_level", 32'(lvl_or), 32'd0);

        // 10-cycle press in RUN: level after 6 cycles, clock paused, restart from 0
        KEY = 1'b0;
        run(5);
        check("deb_lat_before", 32'(KEY_LEVEL), 32'd0);
        run(1);
        check("deb_lat_at6", 32'(KEY_LEVEL), 32'd1);
        clear_acc();
        run(4);
        KEY = 1'b1;
        run(6);
        check("pause_no_clk", 32'(hi_cnt), 32'd0);
        check("release_level", 32'(KEY_LEVEL), 32'd0);
        clear_acc();
        run(16);
        check("resume_pattern", 32'(pat[15:0]), 32'h0000_F0F0);

        // 40-cycle hold in RUN switches to STEP with no clock
        KEY = 1'b0;
        run(8);
        clear_acc();
        run(32);
        check("long_mode_step", 32'(MODE), 32'd1);
        KEY = 1'b1;
        run(20);
        check("long_no_clk", 32'(hi_cnt), 32'd0);
        check("step_idle_clk", 32'(CPU_CLK), 32'd0);
        check("step_idle_busy", 32'(BUSY), 32'd0);
        check("step_idle_mode", 32'(MODE), 32'd1);

        // One short press: 2-cycle pulse one cycle after the debounced fall
        clear_acc();
        short_press();
        check("step_pulse", 32'(pat[29:0]), 32'h0003_0000);
        check("step_busy", 32'(busy_pat[29:0]), 32'h0003_0000);
        short_press();
        short_press();
        check("step_three_rises", 32'(rise_cnt), 32'd3);
        check("step_three_high", 32'(hi_cnt), 32'd6);
`ifdef TD4_STEP_COUNT_EN
        check("step_count", 32'(STEP_COUNT), 32'(tot_rise[7:0]));
`endif

        // 40-cycle hold in STEP returns to RUN without a pulse
        clear_acc();
        KEY = 1'b0;
        run(40);
        check("step_long_mode_run", 32'(MODE), 32'd0);
        KEY = 1'b1;
        run(7);
        check("step_long_no_pulse", 32'(hi_cnt), 32'd0);
        clear_acc();
        run(16);
        check("back_run_pattern", 32'(pat[15:0]), 32'h0000_F0F0);

        // Back to STEP, then reset in the middle of a pulse
        KEY = 1'b0;
        run(40);
        KEY = 1'b1;
        run(20);
        check("reenter_step", 32'(MODE), 32'd1);
        KEY = 1'b0;
        run(10);
        KEY = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run(1);
            if (CPU_CLK) found = 1'b1;
        end
        check("pulse_seen", 32'(found), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_clk", 32'(CPU_CLK), 32'd0);
        check("async_rst_mode", 32'(MODE), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        clear_acc();
        run(16);
        check("post_rst_pattern", 32'(pat[15:0]), 32'h0000_F0F0);
        check("post_rst_mode", 32'(MODE), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
